ov7670_vga_display: RTL and testbench



---
 rtl/ov7670_vga_display.sv | 134 +++++++++++++
 tb/tb_ov7670_vga_display.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ov7670_vga_display.sv
// VGA scan-out for the OV7670 frame buffer: 640x480@60 timing, linear RAM read
// addressing and a fixed 3-clock pipeline so colour, blank and syncs move together.
module ov7670_vga_display #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              resetn,
   output logic [ADDR_W-1:0] frame_addr,
   input  logic [11:0]       frame_pixel,
   output logic [3:0]        vga_red,
   output logic [3:0]        vga_green,
   output logic [3:0]        vga_blue,
   output logic              vga_hsync,
   output logic              vga_vsync,
   output logic              blank,
   output logic              frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CW      = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

   localparam logic [CW-1:0]     H_ACT_C   = CW'(H_ACTIVE);
   localparam logic [CW-1:0]     H_LAST    = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0]     HS_START  = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0]     HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0]     V_ACT_C   = CW'(V_ACTIVE);
   localparam logic [CW-1:0]     V_LAST    = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0]     VS_START  = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0]     VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   logic [CW-1:0]     hcnt;
   logic [CW-1:0]     vcnt;
   logic [ADDR_W-1:0] addr_cnt;
   logic              active;
   logic              hs_raw;
   logic              vs_raw;
   logic              first_px;
   logic              frame_end;

   assign active    = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
   assign hs_raw    = !((hcnt >= HS_START) && (hcnt < HS_END));
   assign vs_raw    = !((vcnt >= VS_START) && (vcnt < VS_END));
   assign first_px  = (hcnt == '0) && (vcnt == '0);
   assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would let later stages see this edge's update.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
      end else begin
         hcnt <= hcnt + CW'(1);
      end
   end

   // Forcing addr_cnt to 0 at the last counter position re-aligns each frame
   // even if the count ever drifted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_cnt   <= '0;
         frame_addr <= '0;
      end else begin
         if (active) frame_addr <= addr_cnt;
         if (frame_end)
            addr_cnt <= '0;
         else if (active)
            addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + ADDR_W'(1);
      end
   end

   logic active_d1, active_d2;
   logic hs_d1, hs_d2;
   logic vs_d1, vs_d2;
   logic first_d1, first_d2;

   // Two delay stages here; the output registers form the third, matching the
   // address register plus the RAM's one-clock read latency.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         active_d1 <= 1'b0;
         active_d2 <= 1'b0;
         hs_d1     <= 1'b1;
         hs_d2     <= 1'b1;
         vs_d1     <= 1'b1;
         vs_d2     <= 1'b1;
         first_d1  <= 1'b0;
         first_d2  <= 1'b0;
      end else begin
         active_d1 <= active;
         active_d2 <= active_d1;
         hs_d1     <= hs_raw;
         hs_d2     <= hs_d1;
         vs_d1     <= vs_raw;
         vs_d2     <= vs_d1;
         first_d1  <= first_px;
         first_d2  <= first_d1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vga_red     <= 4'h0;
         vga_green   <= 4'h0;
         vga_blue    <= 4'h0;
         vga_hsync   <= 1'b1;
         vga_vsync   <= 1'b1;
         blank       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         vga_red     <= active_d2 ? frame_pixel[11:8] : 4'h0;
         vga_green   <= active_d2 ? frame_pixel[7:4]  : 4'h0;
         vga_blue    <= active_d2 ? frame_pixel[3:0]  : 4'h0;
         vga_hsync   <= hs_d2;
         vga_vsync   <= vs_d2;
         blank       <= !active_d2;
         frame_start <= first_d2;
      end
   end

endmodule

// File: tb/tb_ov7670_vga_display.sv
// Directed bench for ov7670_vga_display. Lines are full width; the frame is
// shortened to 6 visible lines (V_TOTAL=12, 9600 clks) so two frames run quickly.
module tb_ov7670_vga_display;

   localparam int ADDR_W = 19;

   logic              clk = 1'b0;
   logic              resetn;
   logic [ADDR_W-1:0] frame_addr;
   logic [11:0]       frame_pixel = 12'h000;
   logic [3:0]        vga_red, vga_green, vga_blue;
   logic              vga_hsync, vga_vsync, blank, frame_start;

   int pass_cnt = 0;
   int total_cnt = 0;
   int edge_cnt;

   ov7670_vga_display #(
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .resetn(resetn), .frame_addr(frame_addr), .frame_pixel(frame_pixel),
      .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .blank(blank),
      .frame_start(frame_start)
   );

   always #20 clk = ~clk;

   // RAM model: returns the low 12 address bits one clock after the address.
   always @(posedge clk) frame_pixel <= frame_addr[11:0];

   // Rising edges since the last reset release.
   always @(posedge clk or negedge resetn)
      if (!resetn) edge_cnt <= 0;
      else         edge_cnt <= edge_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Advance to the falling edge that follows rising edge k after release.
   task automatic at_edge(input int k);
      while (edge_cnt < k) @(negedge clk);
   endtask

   function automatic logic [11:0] rgb();
      return {vga_red, vga_green, vga_blue};
   endfunction

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      resetn = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_rgb",   rgb(),       12'h000);
      check("rst_hsync", vga_hsync,   1'b1);
      check("rst_vsync", vga_vsync,   1'b1);
      check("rst_blank", blank,       1'b1);
      check("rst_addr",  frame_addr,  19'd0);
      check("rst_fs",    frame_start, 1'b0);
      resetn = 1'b1;

      at_edge(1);    check("addr_first", frame_addr, 19'd0);
      at_edge(2);    check("fs_early", frame_start, 1'b0);
                     check("blank_early", blank, 1'b1);
      at_edge(3);    check("fs_pulse", frame_start, 1'b1);
                     check("blank_fall", blank, 1'b0);
                     check("rgb_0_0", rgb(), 12'h000);
      at_edge(4);    check("fs_end", frame_start, 1'b0);
                     check("rgb_1_0", rgb(), 12'h001);
      at_edge(640);  check("addr_639", frame_addr, 19'd639);
      at_edge(641);  check("addr_hold", frame_addr, 19'd639);
      at_edge(642);  check("rgb_639_0", rgb(), 12'h27F);
                     check("blank_639_0", blank, 1'b0);
      at_edge(643);  check("blank_rise", blank, 1'b1);
                     check("rgb_blank", rgb(), 12'h000);
      at_edge(658);  check("hs_before", vga_hsync, 1'b1);
      at_edge(659);  check("hs_fall", vga_hsync, 1'b0);
      at_edge(754);  check("hs_low_end", vga_hsync, 1'b0);
      at_edge(755);  check("hs_rise", vga_hsync, 1'b1);
      at_edge(801);  check("addr_640", frame_addr, 19'd640);
      at_edge(803);  check("rgb_0_1", rgb(), 12'h280);
                     check("blank_0_1", blank, 1'b0);
      at_edge(1440); check("addr_1279", frame_addr, 19'd1279);
      at_edge(1442); check("rgb_639_1", rgb(), 12'h4FF);
      at_edge(1443); check("blank_line1", blank, 1'b1);
      at_edge(1458); check("hs_l1_before", vga_hsync, 1'b1);
      at_edge(1459); check("hs_l1_fall", vga_hsync, 1'b0);
      at_edge(4640); check("addr_last", frame_addr, 19'd3839);
      at_edge(4642); check("rgb_last", rgb(), 12'hEFF);
                     check("blank_last", blank, 1'b0);
      at_edge(4643); check("blank_after_last", blank, 1'b1);
      at_edge(4903); check("vblank_l6", blank, 1'b1);
      at_edge(5703); check("vblank_l7", blank, 1'b1);
                     check("vblank_rgb", rgb(), 12'h000);
      at_edge(6402); check("vs_before", vga_vsync, 1'b1);
      at_edge(6403); check("vs_fall", vga_vsync, 1'b0);
      at_edge(7059); check("hs_in_vs", vga_hsync, 1'b0);
                     check("vs_in_vs", vga_vsync, 1'b0);
      at_edge(8002); check("vs_low_end", vga_vsync, 1'b0);
      at_edge(8003); check("vs_rise", vga_vsync, 1'b1);
      at_edge(9600); check("addr_hold_end", frame_addr, 19'd3839);
      at_edge(9601); check("addr_wrap", frame_addr, 19'd0);
      at_edge(9603); check("fs_frame2", frame_start, 1'b1);
                     check("blank_frame2", blank, 1'b0);
                     check("rgb_f2_0_0", rgb(), 12'h000);
      at_edge(9604); check("rgb_f2_1_0", rgb(), 12'h001);

      // Reset while counters sit at (300,3) of the second frame.
      at_edge(12300);
      check("mid_rgb", rgb(), 12'h8A9);
      check("mid_addr", frame_addr, 19'd2219);
      #5 resetn = 1'b0;
      #1;
      check("async_rgb",   rgb(),      12'h000);
      check("async_blank", blank,      1'b1);
      check("async_addr",  frame_addr, 19'd0);
      check("async_hsync", vga_hsync,  1'b1);
      repeat (5) @(negedge clk);
      resetn = 1'b1;
      at_edge(1);    check("re_addr", frame_addr, 19'd0);
      at_edge(2);    check("re_fs_early", frame_start, 1'b0);
      at_edge(3);    check("re_fs", frame_start, 1'b1);
                     check("re_blank", blank, 1'b0);
      at_edge(4);    check("re_rgb_1_0", rgb(), 12'h001);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
